// File: rtl/branch_resolver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_resolver_pkg: shared record type and constants for the      |
// | branch prediction update path.                     rev 1.0         |
// +--------------------------------------------------------------------+
package branch_resolver_pkg;

    localparam int unsigned c_addr_w = 32;
    localparam logic [c_addr_w-1:0] c_pc_inc = 32'd4;

    typedef struct packed {
        logic                valid;
        logic                hit;
        logic                pt;
        logic [c_addr_w-1:0] pc;
        logic [c_addr_w-1:0] ptarget;
    } pred_rec_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolver_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pred_stage_reg: one prediction record stage with hold and squash.  |
// |                                                    rev 1.0         |
// +--------------------------------------------------------------------+
module pred_stage_reg
    import branch_resolver_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      flush,
    input  pred_rec_t d,
    output pred_rec_t q
);

    pred_rec_t r_q;

    // Flush only drops the valid bit; the remaining fields become don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (stall) begin
            r_q <= r_q;
        end else if (flush) begin
            r_q.valid <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_resolver: carries predictions s1->s4, resolves them against |
// | the real outcome, updates the table, flushes, counts.  rev 1.0     |
// +--------------------------------------------------------------------+
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [c_addr_w-1:0] inst_adress_s1,
    input  logic                hit_s1,
    input  logic                p_s1,
    input  logic [c_addr_w-1:0] b_dest_out,
    input  logic                is_branch_s4,
    input  logic                taken_s4,
    input  logic [c_addr_w-1:0] target_s4,
    output logic                write_rt,
    output logic                write_rp,
    output logic                deviated_s4,
    output logic [c_addr_w-1:0] b_dest_in,
    output logic [c_addr_w-1:0] inst_adress_s4,
    output logic                flush,
    output logic [c_addr_w-1:0] redirect_pc,
    output logic [CNT_W-1:0]    branch_cnt,
    output logic [CNT_W-1:0]    mispred_cnt
);

    pred_rec_t        w_rec [0:3];
    pred_rec_t        w_s4;
    logic             w_res;
    logic             w_dir_mp;
    logic             w_tgt_mp;
    logic             w_mp;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    assign w_rec[0] = '{valid:   1'b1,
                        hit:     hit_s1,
                        pt:      hit_s1 & p_s1,
                        pc:      inst_adress_s1,
                        ptarget: b_dest_out};

    for (genvar i = 0; i < 3; i++) begin : g_stage
        pred_stage_reg u_stage (
            .clk   (clk),
            .rst   (rst),
            .stall (stall),
            .flush (w_mp),
            .d     (w_rec[i]),
            .q     (w_rec[i+1])
        );
    end

    assign w_s4 = w_rec[3];

    // A held record must not resolve, so a stalled branch fires exactly once.
    assign w_res    = w_s4.valid & ~stall;
    assign w_dir_mp = w_s4.pt ^ taken_s4;
    assign w_tgt_mp = w_s4.pt & taken_s4 & (w_s4.ptarget != target_s4);
    assign w_mp     = w_res & (is_branch_s4 ? (w_dir_mp | w_tgt_mp) : w_s4.pt);

    assign flush          = w_mp;
    assign redirect_pc    = (is_branch_s4 & taken_s4) ? target_s4 : (w_s4.pc + c_pc_inc);
    assign write_rt       = w_res & is_branch_s4 & taken_s4;
    assign write_rp       = w_res & is_branch_s4 & (w_s4.pt | taken_s4 | w_s4.hit);
    assign deviated_s4    = taken_s4;
    assign b_dest_in      = target_s4;
    assign inst_adress_s4 = w_s4.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_res & is_branch_s4) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mp) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
